// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - shared TAP state, opcode, command and IDCODE field definitions
package jtag_pkg;

    typedef enum logic [3:0] {
        TAP_TLR        = 4'h0,
        TAP_RTI        = 4'h1,
        TAP_SELECT_DR  = 4'h2,
        TAP_CAPTURE_DR = 4'h3,
        TAP_SHIFT_DR   = 4'h4,
        TAP_EXIT1_DR   = 4'h5,
        TAP_PAUSE_DR   = 4'h6,
        TAP_EXIT2_DR   = 4'h7,
        TAP_UPDATE_DR  = 4'h8,
        TAP_SELECT_IR  = 4'h9,
        TAP_CAPTURE_IR = 4'hA,
        TAP_SHIFT_IR   = 4'hB,
        TAP_EXIT1_IR   = 4'hC,
        TAP_PAUSE_IR   = 4'hD,
        TAP_EXIT2_IR   = 4'hE,
        TAP_UPDATE_IR  = 4'hF
    } tap_state_t;

    typedef enum logic [1:0] {
        CMD_NOP       = 2'b00,
        CMD_READ      = 2'b01,
        CMD_WRITE     = 2'b10,
        CMD_WRITE_INC = 2'b11
    } mgmt_cmd_t;

    typedef enum logic [2:0] {
        DR_BYPASS, DR_BSR, DR_IDCODE, DR_USERCODE, DR_MADDR, DR_MDATA
    } dr_sel_t;

    typedef enum logic {TXN_IDLE, TXN_ACTIVE} txn_state_t;

    localparam int OP_EXTEST    = 0;
    localparam int OP_SAMPLE    = 1;
    localparam int OP_INTEST    = 2;
    localparam int OP_USERCODE  = 3;
    localparam int OP_IDCODE    = 4;
    localparam int OP_MGMT_ADDR = 5;
    localparam int OP_MGMT_DATA = 6;

    localparam int VERSION_WIDTH      = 4;
    localparam int PART_WIDTH         = 16;
    localparam int MANUFACTURER_WIDTH = 11;

    function automatic tap_state_t nextTapState(input tap_state_t s, input logic tms);
        case (s)
            TAP_TLR:        return tms ? TAP_TLR       : TAP_RTI;
            TAP_RTI:        return tms ? TAP_SELECT_DR : TAP_RTI;
            TAP_SELECT_DR:  return tms ? TAP_SELECT_IR : TAP_CAPTURE_DR;
            TAP_CAPTURE_DR: return tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_SHIFT_DR:   return tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_EXIT1_DR:   return tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR:   return tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
            TAP_EXIT2_DR:   return tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
            TAP_UPDATE_DR:  return tms ? TAP_SELECT_DR : TAP_RTI;
            TAP_SELECT_IR:  return tms ? TAP_TLR       : TAP_CAPTURE_IR;
            TAP_CAPTURE_IR: return tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_SHIFT_IR:   return tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_EXIT1_IR:   return tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR:   return tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
            TAP_EXIT2_IR:   return tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
            default:        return tms ? TAP_SELECT_DR : TAP_RTI;
        endcase
    endfunction

endpackage

// File: rtl/jtag_tap_mgmt_if.sv
// rtl/jtag_tap_mgmt_if.sv - management bus driven by the TAP (master) toward the core (slave)
interface jtag_tap_mgmt_if #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32
);
    logic                  writeEnable;
    logic                  readEnable;
    logic [3:0]            byteSelect;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] writeData;
    logic [DATA_WIDTH-1:0] readData;
    logic                  busy;

    modport master (
        output writeEnable, readEnable, byteSelect, address, writeData,
        input  readData, busy
    );

    modport slave (
        input  writeEnable, readEnable, byteSelect, address, writeData,
        output readData, busy
    );
endinterface

// File: rtl/jtag_shift_register.sv
// rtl/jtag_shift_register.sv - capture/shift register used for the IR and every DR
module jtag_shift_register
    import jtag_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture,
    input  logic             shift,
    input  logic             serialIn,
    input  logic [WIDTH-1:0] captureData,
    output logic [WIDTH-1:0] parallelOut
);
    // Shift toward the LSB; tdi enters at the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parallelOut <= '0;
        end else if (capture) begin
            parallelOut <= captureData;
        end else if (shift) begin
            parallelOut <= WIDTH'({serialIn, parallelOut} >> 1);
        end
    end
endmodule

// File: rtl/jtag_tap_mgmt.sv
// rtl/jtag_tap_mgmt.sv - oversampled 1149.1 TAP with management-bus access registers
module jtag_tap_mgmt
    import jtag_pkg::*;
#(
    parameter int IR_WIDTH    = 5,
    parameter int ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH  = 32,
    parameter int BSR_WIDTH   = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [31:0]                   coreID,
    input  logic [MANUFACTURER_WIDTH-1:0] manufacturerID,
    input  logic [PART_WIDTH-1:0]         partID,
    input  logic [VERSION_WIDTH-1:0]      versionID,
    input  logic                          jtag_tck,
    input  logic                          jtag_tms,
    input  logic                          jtag_tdi,
    output logic                          jtag_tdo,
    jtag_tap_mgmt_if.master               management,
    output logic [IR_WIDTH-1:0]           probe_jtagInstruction,
    output logic [3:0]                    probe_jtagState
);
    logic [SYNC_STAGES-1:0] tckSync, tmsSync, tdiSync;
    logic tckHist, tckRise, tckFall, tmsS, tdiS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tckSync <= '0;
            tmsSync <= '0;
            tdiSync <= '0;
            tckHist <= 1'b0;
        end else begin
            tckSync <= {tckSync[SYNC_STAGES-2:0], jtag_tck};
            tmsSync <= {tmsSync[SYNC_STAGES-2:0], jtag_tms};
            tdiSync <= {tdiSync[SYNC_STAGES-2:0], jtag_tdi};
            tckHist <= tckSync[SYNC_STAGES-1];
        end
    end

    assign tckRise = tckSync[SYNC_STAGES-1] & ~tckHist;
    assign tckFall = ~tckSync[SYNC_STAGES-1] & tckHist;
    assign tmsS    = tmsSync[SYNC_STAGES-1];
    assign tdiS    = tdiSync[SYNC_STAGES-1];

    tap_state_t            state;
    logic [IR_WIDTH-1:0]   instruction;
    dr_sel_t               drSel;
    logic                  captureDr, shiftDr, captureIr, shiftIr, updateDr, drOut, tdoNext;
    logic [IR_WIDTH-1:0]   irQ;
    logic [BSR_WIDTH-1:0]  bsrQ;
    logic [31:0]           idQ, userQ;
    logic                  bypassQ;
    logic [ADDR_WIDTH+3:0] addrQ;
    logic [DATA_WIDTH+1:0] dataQ;
    logic                  unusedDrBits;

    txn_state_t            txnState;
    logic                  wrEn, rdEn, autoInc, overrun;
    logic [3:0]            byteSel;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata, readLatch;
    mgmt_cmd_t             cmd;

    assign captureDr = tckRise && state == TAP_CAPTURE_DR;
    assign shiftDr   = tckRise && state == TAP_SHIFT_DR;
    assign captureIr = tckRise && state == TAP_CAPTURE_IR;
    assign shiftIr   = tckRise && state == TAP_SHIFT_IR;
    assign updateDr  = tckFall && state == TAP_UPDATE_DR;
    assign cmd       = mgmt_cmd_t'(dataQ[1:0]);

    always_comb begin
        drSel = DR_BYPASS;
        case (instruction)
            IR_WIDTH'(OP_EXTEST), IR_WIDTH'(OP_SAMPLE), IR_WIDTH'(OP_INTEST): drSel = DR_BSR;
            IR_WIDTH'(OP_IDCODE):    drSel = DR_IDCODE;
            IR_WIDTH'(OP_USERCODE):  drSel = DR_USERCODE;
            IR_WIDTH'(OP_MGMT_ADDR): drSel = DR_MADDR;
            IR_WIDTH'(OP_MGMT_DATA): drSel = DR_MDATA;
            default:                 drSel = DR_BYPASS;
        endcase
    end

    jtag_shift_register #(.WIDTH(IR_WIDTH)) irReg (
        .clk(clk), .rst_n(rst_n), .capture(captureIr), .shift(shiftIr), .serialIn(tdiS),
        .captureData(IR_WIDTH'(2'b01)), .parallelOut(irQ));
    jtag_shift_register #(.WIDTH(BSR_WIDTH)) bsrReg (
        .clk(clk), .rst_n(rst_n), .capture(captureDr && drSel == DR_BSR),
        .shift(shiftDr && drSel == DR_BSR), .serialIn(tdiS),
        .captureData('0), .parallelOut(bsrQ));
    jtag_shift_register #(.WIDTH(32)) idReg (
        .clk(clk), .rst_n(rst_n), .capture(captureDr && drSel == DR_IDCODE),
        .shift(shiftDr && drSel == DR_IDCODE), .serialIn(tdiS),
        .captureData({versionID, partID, manufacturerID, 1'b1}), .parallelOut(idQ));
    jtag_shift_register #(.WIDTH(32)) userReg (
        .clk(clk), .rst_n(rst_n), .capture(captureDr && drSel == DR_USERCODE),
        .shift(shiftDr && drSel == DR_USERCODE), .serialIn(tdiS),
        .captureData(coreID), .parallelOut(userQ));
    jtag_shift_register #(.WIDTH(1)) bypassReg (
        .clk(clk), .rst_n(rst_n), .capture(captureDr && drSel == DR_BYPASS),
        .shift(shiftDr && drSel == DR_BYPASS), .serialIn(tdiS),
        .captureData(1'b0), .parallelOut(bypassQ));
    jtag_shift_register #(.WIDTH(ADDR_WIDTH+4)) maddrReg (
        .clk(clk), .rst_n(rst_n), .capture(captureDr && drSel == DR_MADDR),
        .shift(shiftDr && drSel == DR_MADDR), .serialIn(tdiS),
        .captureData({addr, byteSel}), .parallelOut(addrQ));
    jtag_shift_register #(.WIDTH(DATA_WIDTH+2)) mdataReg (
        .clk(clk), .rst_n(rst_n), .capture(captureDr && drSel == DR_MDATA),
        .shift(shiftDr && drSel == DR_MDATA), .serialIn(tdiS),
        .captureData({readLatch, overrun, txnState == TXN_ACTIVE}), .parallelOut(dataQ));

    // Only the LSB of the read-only registers ever leaves the chip.
    assign unusedDrBits = ^{bsrQ[BSR_WIDTH-1:1], idQ[31:1], userQ[31:1]};

    always_comb begin
        drOut = bypassQ;
        case (drSel)
            DR_BSR:      drOut = bsrQ[0];
            DR_IDCODE:   drOut = idQ[0];
            DR_USERCODE: drOut = userQ[0];
            DR_MADDR:    drOut = addrQ[0];
            DR_MDATA:    drOut = dataQ[0];
            default:     drOut = bypassQ;
        endcase
        tdoNext = 1'b0;
        if (state == TAP_SHIFT_DR)      tdoNext = drOut;
        else if (state == TAP_SHIFT_IR) tdoNext = irQ[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= TAP_TLR;
            instruction <= IR_WIDTH'(OP_IDCODE);
            jtag_tdo    <= 1'b0;
        end else begin
            if (tckRise) begin
                state <= nextTapState(state, tmsS);
                if (state == TAP_TLR) instruction <= IR_WIDTH'(OP_IDCODE);
            end
            if (tckFall) begin
                jtag_tdo <= tdoNext;
                if (state == TAP_UPDATE_IR) instruction <= irQ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txnState  <= TXN_IDLE;
            wrEn      <= 1'b0;
            rdEn      <= 1'b0;
            autoInc   <= 1'b0;
            overrun   <= 1'b0;
            byteSel   <= 4'hF;
            addr      <= '0;
            wdata     <= '0;
            readLatch <= '0;
        end else begin
            if (captureDr && drSel == DR_MDATA) overrun <= 1'b0;
            case (txnState)
                TXN_IDLE: begin
                    if (updateDr && drSel == DR_MADDR) begin
                        addr    <= addrQ[ADDR_WIDTH+3:4];
                        byteSel <= addrQ[3:0];
                    end
                    if (updateDr && drSel == DR_MDATA && cmd != CMD_NOP) begin
                        txnState <= TXN_ACTIVE;
                        rdEn     <= cmd == CMD_READ;
                        wrEn     <= cmd != CMD_READ;
                        autoInc  <= cmd == CMD_WRITE_INC;
                        if (cmd != CMD_READ) wdata <= dataQ[DATA_WIDTH+1:2];
                    end
                end
                default: begin
                    if (updateDr && drSel == DR_MDATA && cmd != CMD_NOP) overrun <= 1'b1;
                    if (!management.busy) begin
                        txnState <= TXN_IDLE;
                        wrEn     <= 1'b0;
                        rdEn     <= 1'b0;
                        if (rdEn)    readLatch <= management.readData;
                        if (autoInc) addr      <= addr + ADDR_WIDTH'(1);
                    end
                end
            endcase
        end
    end

    assign management.writeEnable = wrEn;
    assign management.readEnable  = rdEn;
    assign management.byteSelect  = byteSel;
    assign management.address     = addr;
    assign management.writeData   = wdata;
    assign probe_jtagInstruction  = instruction;
    assign probe_jtagState        = state;
endmodule
